// File: rtl/dpram_arb_pkg.sv
// Shared types and helpers for the dual-port RAM port arbiter.
// The LOCKED state is only used when DPRAM_ARB_LOCK_EN is defined.
package dpram_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int MAX_IW  = $clog2(MAX_REQ);

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Index to one-hot vector over the largest supported requester count.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_IW-1:0] idx);
    logic [MAX_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dpram_port_arbiter_rr_pick.sv
// Rotating-priority picker. The search starts at ptr_i and ascends,
// wrapping modulo N. This is written out explicitly, so N does not
// need to be a power of two.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // The first requester found, counting upward from ptr_i, wins.
  always_comb begin : pick
    int   j;
    logic found;
    j       = 0;
    found   = 1'b0;
    grant_o = '0;
    idx_o   = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!found && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter that shares one RAM port among NUM_REQ requesters.
// A read returns a one-hot tagged response one cycle after it is issued.
// Optional grant lock for read-modify-write sequences: DPRAM_ARB_LOCK_EN.
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int AWIDTH  = 10,
  parameter int DWIDTH  = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_wren,
  input  logic [NUM_REQ*AWIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DWIDTH-1:0] req_data,
  input  logic [NUM_REQ*DWIDTH/8-1:0] req_byteen,
`ifdef DPRAM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DWIDTH-1:0]         rsp_data,
  output logic [AWIDTH-1:0]         ram_address,
  output logic                      ram_wren,
  output logic [DWIDTH-1:0]         ram_data,
  output logic [DWIDTH/8-1:0]       ram_byteen,
  input  logic [DWIDTH-1:0]         ram_out
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = DWIDTH / 8;

  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]      rsp_tag_q, rsp_tag_d;
  logic               rsp_pend_q, rsp_pend_d;
  logic [NUM_REQ-1:0] lock_mask;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IW-1:0]      g;
  logic               pick_any;
  logic               xfer;
  logic [MAX_REQ-1:0] tag_oh;

`ifdef DPRAM_ARB_LOCK_EN
  arb_state_t         state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [MAX_REQ-1:0] owner_oh;

  // Lock FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ARB;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Lock FSM next state. When LOCKED, only the owner can transfer.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      ARB: begin
        if (xfer && req_lock[g]) begin
          state_d = LOCKED;
          owner_d = g;
        end
      end
      LOCKED: begin
        if (xfer && !req_lock[g]) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  // Lock FSM output: restrict the candidate set to the owner while locked.
  always_comb begin
    owner_oh  = onehot(MAX_IW'(owner_q));
    lock_mask = '1;
    if (state_q == LOCKED) lock_mask = owner_oh[NUM_REQ-1:0];
  end
`else
  // Without the lock feature, every requester can always be granted.
  always_comb begin
    lock_mask = '1;
  end
`endif

  assign cand = req_valid & lock_mask;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req_i   (cand),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (g),
    .any_o   (pick_any)
  );

  // A grant is a transfer, because only valid requesters are candidates.
  // Gating with resetn keeps the grant and writes off while reset is asserted.
  assign req_ready = pick_grant & {NUM_REQ{resetn}};
  assign xfer      = pick_any & resetn;

  // Combinational RAM request mux. With no grant, all RAM outputs are zero.
  always_comb begin
    ram_address = '0;
    ram_wren    = 1'b0;
    ram_data    = '0;
    ram_byteen  = '0;
    if (xfer) begin
      ram_address = req_addr[int'(g)*AWIDTH +: AWIDTH];
      ram_wren    = req_wren[g];
      ram_data    = req_data[int'(g)*DWIDTH +: DWIDTH];
      ram_byteen  = req_byteen[int'(g)*BW +: BW];
    end
  end

  // Next-state logic for the rotating pointer and the pending-response tracker.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    rsp_tag_d  = rsp_tag_q;
    rsp_pend_d = 1'b0;
    if (xfer) begin
      rr_ptr_d   = (g == IW'(NUM_REQ - 1)) ? '0 : g + IW'(1);
      rsp_tag_d  = g;
      rsp_pend_d = ~req_wren[g];
    end
  end

  // Arbiter state registers. Reset drops any response still in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr_q   <= '0;
      rsp_tag_q  <= '0;
      rsp_pend_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rsp_tag_q  <= rsp_tag_d;
      rsp_pend_q <= rsp_pend_d;
    end
  end

  // Response: the tag is one-hot and is qualified by the pending flag.
  // The data is the RAM's registered output, broadcast to all requesters.
  always_comb begin
    tag_oh    = onehot(MAX_IW'(rsp_tag_q));
    rsp_valid = tag_oh[NUM_REQ-1:0] & {NUM_REQ{rsp_pend_q}};
    rsp_data  = ram_out;
  end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter. It includes a registered-read RAM model.
// The lock scenario is compiled only when DPRAM_ARB_LOCK_EN is defined.
module tb_dpram_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic              clk = 1'b0;
  logic              resetn;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      req_wren;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic [N*BW-1:0]   req_byteen;
`ifdef DPRAM_ARB_LOCK_EN
  logic [N-1:0]      req_lock;
`endif
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic [AW-1:0]     ram_address;
  logic              ram_wren;
  logic [DW-1:0]     ram_data;
  logic [BW-1:0]     ram_byteen;
  logic [DW-1:0]     ram_out;

  logic              pl_we;
  logic [AW-1:0]     pl_addr;
  logic [DW-1:0]     pl_data;
  logic [DW-1:0]     mem [0:(1<<AW)-1];

  int n_chk;
  int n_err;

  always #5 clk = ~clk;

  dpram_port_arbiter #(
    .NUM_REQ (N),
    .AWIDTH  (AW),
    .DWIDTH  (DW)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wren    (req_wren),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_byteen  (req_byteen),
`ifdef DPRAM_ARB_LOCK_EN
    .req_lock    (req_lock),
`endif
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .ram_address (ram_address),
    .ram_wren    (ram_wren),
    .ram_data    (ram_data),
    .ram_byteen  (ram_byteen),
    .ram_out     (ram_out)
  );

  // RAM model with registered read. byteen MSB selects the lowest byte lane.
  always @(posedge clk) begin
    if (pl_we) begin
      mem[pl_addr] <= pl_data;
    end else if (ram_wren) begin
      for (int k = 0; k < BW; k++)
        if (ram_byteen[BW-1-k]) mem[ram_address][8*k +: 8] <= ram_data[8*k +: 8];
    end
    ram_out <= mem[ram_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] be);
    req_valid[i]            = v;
    req_wren[i]             = w;
    req_addr[i*AW +: AW]    = a;
    req_data[i*DW +: DW]    = d;
    req_byteen[i*BW +: BW]  = be;
  endtask

  task automatic clr_req();
    req_valid  = '0;
    req_wren   = '0;
    req_addr   = '0;
    req_data   = '0;
    req_byteen = '0;
`ifdef DPRAM_ARB_LOCK_EN
    req_lock   = '0;
`endif
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic all_read();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(32'h20 + i), '0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_chk  = 0;
    n_err  = 0;
    resetn = 1'b0;
    pl_we  = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    clr_req();

    // During reset, everything requests a write: no grant and no write may escape
    drive_edge();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, '1, '1, '1);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_wren",  32'(ram_wren),  32'h0);
    chk("rst_rsp",   32'(rsp_valid), 32'h0);

    // Preload the RAM while reset is held
    for (int k = 0; k < 10; k++) begin
      drive_edge();
      pl_we = 1'b1;
      if (k < 8)       begin pl_addr = AW'(32'h20 + k); pl_data = 32'hC0DE_0000 + 32'(k); end
      else if (k == 8) begin pl_addr = AW'(32'h10);     pl_data = 32'hDEAD_BEEF; end
      else             begin pl_addr = AW'(32'h5);      pl_data = 32'hAAAA_AAAA; end
    end
    drive_edge();
    pl_we = 1'b0;
    clr_req();
    resetn = 1'b1;

    // Single read by requester 1
    drive_edge();
    set_req(1, 1'b1, 1'b0, AW'(32'h10), '0, '0);
    @(negedge clk);
    chk("rd1_ready", 32'(req_ready),   32'h2);
    chk("rd1_addr",  32'(ram_address), 32'h10);
    chk("rd1_wren",  32'(ram_wren),    32'h0);
    drive_edge();
    clr_req();
    @(negedge clk);
    chk("rd1_rspv",  32'(rsp_valid), 32'h2);
    chk("rd1_rspd",  rsp_data,       32'hDEAD_BEEF);
    chk("rd1_idle",  32'(req_ready), 32'h0);

    // Reset pulse, then all four requesters read continuously
    drive_edge();
    resetn = 1'b0;
    drive_edge();
    resetn = 1'b1;
    for (int c = 0; c < 9; c++) begin
      drive_edge();
      if (c < 8) all_read(); else clr_req();
      @(negedge clk);
      if (c < 8) begin
        chk("rr_grant", 32'(req_ready),   32'(1 << (c % 4)));
        chk("rr_addr",  32'(ram_address), 32'h20 + 32'(c % 4));
      end
      if (c >= 1) begin
        chk("rr_rspv", 32'(rsp_valid), 32'(1 << ((c - 1) % 4)));
        chk("rr_rspd", rsp_data,       32'hC0DE_0000 + 32'((c - 1) % 4));
      end
    end

    // Byte-enabled write by requester 2, then read it back
    drive_edge();
    clr_req();
    set_req(2, 1'b1, 1'b1, AW'(32'h5), 32'h1122_3344, 4'b0101);
    @(negedge clk);
    chk("bw_ready",  32'(req_ready),   32'h4);
    chk("bw_wren",   32'(ram_wren),    32'h1);
    chk("bw_byteen", 32'(ram_byteen),  32'h5);
    chk("bw_data",   ram_data,         32'h1122_3344);
    chk("bw_addr",   32'(ram_address), 32'h5);
    drive_edge();
    set_req(2, 1'b1, 1'b0, AW'(32'h5), '0, '0);
    @(negedge clk);
    chk("bw_norsp",  32'(rsp_valid), 32'h0);
    chk("bw_rready", 32'(req_ready), 32'h4);
    drive_edge();
    clr_req();
    @(negedge clk);
    chk("bw_rspv", 32'(rsp_valid), 32'h4);
    chk("bw_rspd", rsp_data,       32'h11AA_33AA);

    // Requester 0 writes, then requester 1 reads the same address
    drive_edge();
    set_req(0, 1'b1, 1'b1, AW'(32'h7), 32'h5566_7788, 4'hF);
    @(negedge clk);
    chk("wr_ready", 32'(req_ready), 32'h1);
    drive_edge();
    clr_req();
    set_req(1, 1'b1, 1'b0, AW'(32'h7), '0, '0);
    @(negedge clk);
    chk("wr_rready", 32'(req_ready), 32'h2);
    drive_edge();
    clr_req();
    @(negedge clk);
    chk("wr_rspv", 32'(rsp_valid), 32'h2);
    chk("wr_rspd", rsp_data,       32'h5566_7788);

    // Idle for five cycles; the pointer must stay at 2
    for (int c = 0; c < 5; c++) begin
      drive_edge();
      @(negedge clk);
      chk("idle_wren",  32'(ram_wren),    32'h0);
      chk("idle_rspv",  32'(rsp_valid),   32'h0);
      chk("idle_ready", 32'(req_ready),   32'h0);
      chk("idle_addr",  32'(ram_address), 32'h0);
    end
    drive_edge();
    all_read();
    @(negedge clk);
    chk("idle_ptr0", 32'(req_ready), 32'h4);
    drive_edge();
    @(negedge clk);
    chk("idle_ptr1", 32'(req_ready), 32'h8);

    // Reset asserted the cycle after a read grant by requester 1
    drive_edge();
    clr_req();
    set_req(1, 1'b1, 1'b0, AW'(32'h21), '0, '0);
    @(negedge clk);
    chk("rm_ready", 32'(req_ready), 32'h2);
    drive_edge();
    clr_req();
    resetn = 1'b0;
    @(negedge clk);
    chk("rm_rspv_in", 32'(rsp_valid), 32'h0);
    drive_edge();
    resetn = 1'b1;
    @(negedge clk);
    chk("rm_rspv_post", 32'(rsp_valid), 32'h0);
    drive_edge();
    all_read();
    @(negedge clk);
    chk("rm_first", 32'(req_ready), 32'h1);
    drive_edge();
    clr_req();

`ifdef DPRAM_ARB_LOCK_EN
    // Requester 3 locks with a read; requester 0 must stall until the unlock write
    drive_edge();
    set_req(0, 1'b1, 1'b0, AW'(32'h20), '0, '0);
    set_req(3, 1'b1, 1'b0, AW'(32'h23), '0, '0);
    req_lock = 4'b1000;
    @(negedge clk);
    chk("lk_grant3", 32'(req_ready), 32'h8);
    drive_edge();
    set_req(3, 1'b0, 1'b0, '0, '0, '0);
    req_lock = 4'b0000;
    @(negedge clk);
    chk("lk_stall",  32'(req_ready), 32'h0);
    chk("lk_rspv",   32'(rsp_valid), 32'h8);
    chk("lk_rspd",   rsp_data,       32'hC0DE_0003);
    drive_edge();
    set_req(3, 1'b1, 1'b1, AW'(32'h23), 32'h0BAD_F00D, 4'hF);
    @(negedge clk);
    chk("lk_unlock", 32'(req_ready), 32'h8);
    chk("lk_wren",   32'(ram_wren),  32'h1);
    drive_edge();
    set_req(3, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("lk_req0",   32'(req_ready), 32'h1);
    drive_edge();
    clr_req();
`endif

    drive_edge();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
